// File: rtl/rgb_hue_sequencer_if.sv
// Host control port of rgb_hue_sequencer: run/pause level plus the speed
// write strobe and its one-cycle acknowledge.
interface rgb_hue_sequencer_if;
    logic       EN;
    logic       SPEED_WE;
    logic [7:0] SPEED;
    logic       SPEED_ACK;

    modport master (
        output EN,
        output SPEED_WE,
        output SPEED,
        input  SPEED_ACK
    );

    modport slave (
        input  EN,
        input  SPEED_WE,
        input  SPEED,
        output SPEED_ACK
    );
endinterface

// File: rtl/rgb_hue_sequencer.sv
// Walks an active-low RGB LED around the hue wheel using one shared PWM counter.
// Define RAINBOW_GAMMA_EN for square-law gamma on the ramp-derived duty terms.
module rgb_hue_sequencer #(
    parameter int unsigned CLK_DIV      = 1,
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned STEP_PERIODS = 4
) (
    input  logic               CLK,
    input  logic               RST,
    rgb_hue_sequencer_if.slave host,
    output logic [2:0]         LED,
    output logic [2:0]         PHASE,
    output logic               WRAP
);
    localparam int unsigned           PRESC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(CLK_DIV - 1);
    localparam logic [PWM_BITS-1:0]   MAXV       = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE
    } state_t;

    state_t              state;
    logic [PRESC_W-1:0]  presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] ramp;
    logic [7:0]          step_cnt;
    logic [7:0]          speed_reg;
    logic [2:0]          phase;
    logic                speed_ack;

    logic [PWM_BITS-1:0] rterm;
    logic [PWM_BITS-1:0] duty_calc [3];
    logic [PWM_BITS-1:0] duty_src  [3];
    logic [PWM_BITS-1:0] duty_live [3];

    logic tick;
    logic boundary;
    logic step_ev;

    always_comb begin
        tick     = (state != ST_IDLE) && (presc == PRESC_LAST);
        boundary = tick && (pwm_cnt == MAXV);
        step_ev  = boundary && (state == ST_RUN) && ((step_cnt + 8'd1) == speed_reg);
    end

`ifdef RAINBOW_GAMMA_EN
    logic [2*PWM_BITS-1:0] ramp_sq;

    always_comb begin
        ramp_sq = {{PWM_BITS{1'b0}}, ramp} * {{PWM_BITS{1'b0}}, ramp};
        rterm   = ramp_sq[2*PWM_BITS-1:PWM_BITS];
    end
`else
    always_comb rterm = ramp;
`endif

    // Index 0 = R, 1 = G, 2 = B.
    always_comb begin
        duty_calc[0] = '0;
        duty_calc[1] = '0;
        duty_calc[2] = '0;
        case (phase)
            3'd0: begin
                duty_calc[0] = MAXV;
                duty_calc[1] = rterm;
            end
            3'd1: begin
                duty_calc[0] = MAXV - rterm;
                duty_calc[1] = MAXV;
            end
            3'd2: begin
                duty_calc[1] = MAXV;
                duty_calc[2] = rterm;
            end
            3'd3: begin
                duty_calc[1] = MAXV - rterm;
                duty_calc[2] = MAXV;
            end
            3'd4: begin
                duty_calc[0] = rterm;
                duty_calc[2] = MAXV;
            end
            3'd5: begin
                duty_calc[0] = MAXV;
                duty_calc[2] = MAXV - rterm;
            end
            default: ;
        endcase
    end

`ifdef RAINBOW_GAMMA_EN
    // Phase/ramp only move at period boundaries, so the extra stage never
    // changes which duty gets latched.
    logic [PWM_BITS-1:0] duty_pipe [3];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            duty_pipe[0] <= '0;
            duty_pipe[1] <= '0;
            duty_pipe[2] <= '0;
        end else begin
            duty_pipe[0] <= duty_calc[0];
            duty_pipe[1] <= duty_calc[1];
            duty_pipe[2] <= duty_calc[2];
        end
    end

    always_comb begin
        duty_src[0] = duty_pipe[0];
        duty_src[1] = duty_pipe[1];
        duty_src[2] = duty_pipe[2];
    end
`else
    always_comb begin
        duty_src[0] = duty_calc[0];
        duty_src[1] = duty_calc[1];
        duty_src[2] = duty_calc[2];
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= ST_IDLE;
            presc        <= '0;
            pwm_cnt      <= '0;
            ramp         <= '0;
            step_cnt     <= '0;
            speed_reg    <= 8'(STEP_PERIODS);
            phase        <= '0;
            speed_ack    <= 1'b0;
            WRAP         <= 1'b0;
            LED          <= '1;
            duty_live[0] <= '0;
            duty_live[1] <= '0;
            duty_live[2] <= '0;
        end else begin
            speed_ack <= host.SPEED_WE;
            WRAP      <= 1'b0;

            case (state)
                ST_IDLE:  if (host.EN)  state <= ST_RUN;
                ST_RUN:   if (!host.EN) state <= ST_PAUSE;
                ST_PAUSE: if (host.EN)  state <= ST_RUN;
                default:  state <= ST_IDLE;
            endcase

            if (state != ST_IDLE) begin
                presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
                if (tick)
                    pwm_cnt <= pwm_cnt + 1'b1;
                if (boundary) begin
                    duty_live[0] <= duty_src[0];
                    duty_live[1] <= duty_src[1];
                    duty_live[2] <= duty_src[2];
                end
                LED <= {~(pwm_cnt < duty_live[2]),
                        ~(pwm_cnt < duty_live[1]),
                        ~(pwm_cnt < duty_live[0])};
            end else begin
                LED <= '1;
            end

            if (step_ev) begin
                if (ramp == MAXV) begin
                    ramp  <= '0;
                    phase <= (phase == 3'd5) ? 3'd0 : phase + 3'd1;
                    WRAP  <= (phase == 3'd5);
                end else begin
                    ramp <= ramp + 1'b1;
                end
            end

            // A write coincident with a step event still lets the step use the old speed.
            if (host.SPEED_WE) begin
                speed_reg <= (host.SPEED == 8'd0) ? 8'd1 : host.SPEED;
                step_cnt  <= '0;
            end else if (step_ev) begin
                step_cnt <= '0;
            end else if (boundary && (state == ST_RUN)) begin
                step_cnt <= step_cnt + 8'd1;
            end
        end
    end

    assign PHASE          = phase;
    assign host.SPEED_ACK = speed_ack;
endmodule
